// File: rtl/logic_unit_pipe.sv
// Pipelined RV32I/Zbb logical unit (XOR/OR/AND plus XNOR/ORN/ANDN) with valid/ready, tag and flush.
// The operation is evaluated into stage 1; later stages only carry {valid, result, tag, illegal} toward writeback.
module logic_unit_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_x,
   input  logic [XLEN-1:0]  in_y,
   input  logic [2:0]       in_funct3,
   input  logic             in_inv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   logic [STAGES-1:0]            stg_valid;
   logic [STAGES-1:0][XLEN-1:0]  stg_result;
   logic [STAGES-1:0][TAG_W-1:0] stg_tag;
   logic [STAGES-1:0]            stg_illegal;
   logic [STAGES-1:0]            stg_load;
   logic [STAGES-1:0]            stg_move;

   logic [XLEN-1:0] y_eff;
   logic [XLEN-1:0] calc_result;
   logic            calc_illegal;
   logic            accept;

   // Unsupported encodings yield a clean zero result so nothing downstream ever sees X.
   always_comb begin
      y_eff        = in_inv ? ~in_y : in_y;
      calc_result  = '0;
      calc_illegal = 1'b0;
      case (in_funct3)
         F3_XOR:  calc_result = in_x ^ y_eff;
         F3_OR:   calc_result = in_x | y_eff;
         F3_AND:  calc_result = in_x & y_eff;
         default: calc_illegal = 1'b1;
      endcase
   end

   // Ready ripples back from the consumer: a stage can load when empty or when its occupant leaves.
   always_comb begin
      stg_move = '0;
      stg_load = '0;
      stg_move[STAGES-1] = stg_valid[STAGES-1] && out_ready;
      stg_load[STAGES-1] = !stg_valid[STAGES-1] || stg_move[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         stg_move[i] = stg_valid[i] && stg_load[i+1];
         stg_load[i] = !stg_valid[i] || stg_move[i];
      end
   end

   assign in_ready = !flush && stg_load[0];
   assign accept   = in_valid && in_ready;

   // Data registers only load alongside a valid entry so an idle output holds its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid   <= '0;
         stg_result  <= '0;
         stg_tag     <= '0;
         stg_illegal <= '0;
      end else if (flush) begin
         stg_valid <= '0;
      end else begin
         if (stg_load[0]) begin
            stg_valid[0] <= accept;
            if (accept) begin
               stg_result[0]  <= calc_result;
               stg_tag[0]     <= in_tag;
               stg_illegal[0] <= calc_illegal;
            end
         end
         for (int i = 1; i < STAGES; i++) begin
            if (stg_load[i]) begin
               stg_valid[i] <= stg_valid[i-1];
               if (stg_valid[i-1]) begin
                  stg_result[i]  <= stg_result[i-1];
                  stg_tag[i]     <= stg_tag[i-1];
                  stg_illegal[i] <= stg_illegal[i-1];
               end
            end
         end
      end
   end

   assign out_valid   = stg_valid[STAGES-1];
   assign out_result  = stg_result[STAGES-1];
   assign out_tag     = stg_tag[STAGES-1];
   assign out_illegal = stg_illegal[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised checks of logic_unit_pipe across several parameter sets.
// Four instances share clock, reset and flush; each scenario task drives and checks one or two of them.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   cyc = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared operand bus for the two 32-bit instances.
   logic [31:0] in_x = '0, in_y = '0;
   logic [2:0]  in_funct3 = '0;
   logic        in_inv = 1'b0;
   logic [4:0]  in_tag = '0;

   logic v2 = 1'b0, or2 = 1'b0, ir2, ov2, ill2;
   logic [31:0] res2;
   logic [4:0]  tag2;
   logic v3 = 1'b0, or3 = 1'b0, ir3, ov3, ill3;
   logic [31:0] res3;
   logic [4:0]  tag3;

   // Shared random bus for the sweep instances (8-bit uses the low byte).
   logic [63:0] sx = '0, sy = '0;
   logic [2:0]  sf = '0;
   logic        sinv = 1'b0, stag = 1'b0, sv = 1'b0;
   logic or1 = 1'b0, ir1, ov1, ill1, tg1;
   logic [7:0]  res1;
   logic or4 = 1'b0, ir4, ov4, ill4, tg4;
   logic [63:0] res4;

   logic_unit_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(v2), .in_ready(ir2),
      .in_x(in_x), .in_y(in_y), .in_funct3(in_funct3), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(ov2), .out_ready(or2), .out_result(res2), .out_tag(tag2), .out_illegal(ill2));

   logic_unit_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(v3), .in_ready(ir3),
      .in_x(in_x), .in_y(in_y), .in_funct3(in_funct3), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(ov3), .out_ready(or3), .out_result(res3), .out_tag(tag3), .out_illegal(ill3));

   logic_unit_pipe #(.XLEN(8), .STAGES(1), .TAG_W(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(sv), .in_ready(ir1),
      .in_x(sx[7:0]), .in_y(sy[7:0]), .in_funct3(sf), .in_inv(sinv), .in_tag(stag),
      .out_valid(ov1), .out_ready(or1), .out_result(res1), .out_tag(tg1), .out_illegal(ill1));

   logic_unit_pipe #(.XLEN(64), .STAGES(4), .TAG_W(1)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(sv), .in_ready(ir4),
      .in_x(sx), .in_y(sy), .in_funct3(sf), .in_inv(sinv), .in_tag(stag),
      .out_valid(ov4), .out_ready(or4), .out_result(res4), .out_tag(tg4), .out_illegal(ill4));

   typedef struct {
      logic [63:0] res;
      logic        tag;
      logic        ill;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];

   // Reference behaviour: {illegal, result}.
   function automatic logic [64:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                          input logic [2:0] f, input logic inv);
      logic [63:0] yy;
      yy = inv ? ~y : y;
      case (f)
         3'b100:  return {1'b0, x ^ yy};
         3'b110:  return {1'b0, x | yy};
         3'b111:  return {1'b0, x & yy};
         default: return {1'b1, 64'h0};
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                input logic [2:0] f, input logic inv, input logic [4:0] tag);
      in_x      = x;
      in_y      = y;
      in_funct3 = f;
      in_inv    = inv;
      in_tag    = tag;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_compared++;
      if ({ov2, res2, tag2, ill2, ir2} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1}) begin
         n_mismatched++;
         $display("[TB] FAIL reset_s2: got v=%b r=%h t=%h i=%b rdy=%b, want 0/0/0/0/1", ov2, res2, tag2, ill2, ir2);
      end
      n_compared++;
      if ({ov3, res3, tag3, ill3, ir3} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1}) begin
         n_mismatched++;
         $display("[TB] FAIL reset_s3: got v=%b r=%h t=%h i=%b rdy=%b, want 0/0/0/0/1", ov3, res3, tag3, ill3, ir3);
      end
      n_compared++;
      if ({ov1, ov4, ir1, ir4} !== 4'b0011) begin
         n_mismatched++;
         $display("[TB] FAIL reset_sweep: got ov1=%b ov4=%b ir1=%b ir4=%b, want 0 0 1 1", ov1, ov4, ir1, ir4);
      end
      next_cycle();
   endtask

   task automatic test_basic_ops();
      logic [2:0]  f3s [6] = '{3'b100, 3'b110, 3'b111, 3'b100, 3'b110, 3'b111};
      logic [31:0] want [6] = '{32'hFF00_12CB, 32'hFFF0_12FF, 32'h00F0_0034,
                                32'h00FF_ED34, 32'hF0FF_FF34, 32'hF000_1200};
      or2 = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c < 6) begin
            applyStimulus(32'hF0F0_1234, 32'h0FF0_00FF, f3s[c], c >= 3, 5'(c + 1));
            v2 = 1'b1;
         end else begin
            v2 = 1'b0;
         end
         @(negedge clk);
         if (c < 6) begin
            n_compared++;
            if (ir2 !== 1'b1) begin
               n_mismatched++;
               $display("[TB] FAIL basic_ready c=%0d: got %b want 1", c, ir2);
            end
         end
         n_compared++;
         if (c >= 2 && c < 8) begin
            if ({ov2, tag2, res2, ill2} !== {1'b1, 5'(c - 1), want[c-2], 1'b0}) begin
               n_mismatched++;
               $display("[TB] FAIL basic_out c=%0d: got v=%b t=%0d r=%h i=%b, want 1/%0d/%h/0",
                        c, ov2, tag2, res2, ill2, c - 1, want[c-2]);
            end
         end else if (ov2 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_idle c=%0d: got out_valid=%b want 0", c, ov2);
         end
         next_cycle();
      end
   endtask

   task automatic test_illegal();
      logic [2:0] f3s [2] = '{3'b000, 3'b101};
      or2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c < 2) begin
            applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, f3s[c], c == 1, 5'(9 + c));
            v2 = 1'b1;
         end else begin
            v2 = 1'b0;
         end
         @(negedge clk);
         if (c >= 2) begin
            n_compared++;
            if ({ov2, tag2, res2, ill2} !== {1'b1, 5'(7 + c), 32'h0, 1'b1}) begin
               n_mismatched++;
               $display("[TB] FAIL illegal c=%0d: got v=%b t=%0d r=%h i=%b, want 1/%0d/0/1",
                        c, ov2, tag2, res2, ill2, 7 + c);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_back_pressure();
      int next_in = 0;
      logic exp_rdy;
      v2 = 1'b0;
      for (int c = 0; c < 14; c++) begin
         v3  = next_in < 8;
         or3 = c >= 5;
         applyStimulus(32'hA500_0000 | 32'(next_in), 32'h0, 3'b100, 1'b0, 5'(next_in));
         @(negedge clk);
         exp_rdy = !(c == 3 || c == 4);
         n_compared++;
         if (ir3 !== exp_rdy) begin
            n_mismatched++;
            $display("[TB] FAIL bp_ready c=%0d: got %b want %b", c, ir3, exp_rdy);
         end
         n_compared++;
         if (c >= 3 && c <= 12) begin
            if ({ov3, tag3, res3, ill3} !== {1'b1, 5'((c <= 5) ? 0 : c - 5),
                                             32'hA500_0000 | 32'((c <= 5) ? 0 : c - 5), 1'b0}) begin
               n_mismatched++;
               $display("[TB] FAIL bp_out c=%0d: got v=%b t=%0d r=%h i=%b, want tag %0d",
                        c, ov3, tag3, res3, ill3, (c <= 5) ? 0 : c - 5);
            end
         end else if (ov3 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_idle c=%0d: got out_valid=%b want 0", c, ov3);
         end
         if (v3 && ir3) next_in++;
         next_cycle();
      end
      v3 = 1'b0;
   endtask

   task automatic test_flush();
      or2 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         v2    = c <= 2;
         flush = c == 2;
         or2   = c >= 3;
         applyStimulus(32'h1111_0000, 32'h0000_2222, 3'b110, 1'b0, 5'(20 + c));
         @(negedge clk);
         if (c == 2) begin
            n_compared++;
            if ({ir2, ov2, tag2} !== {1'b0, 1'b1, 5'd20}) begin
               n_mismatched++;
               $display("[TB] FAIL flush_cycle: got rdy=%b v=%b t=%0d, want 0/1/20", ir2, ov2, tag2);
            end
         end else if (c >= 3) begin
            n_compared++;
            if ({ov2, ir2} !== 2'b01) begin
               n_mismatched++;
               $display("[TB] FAIL flush_after c=%0d: got v=%b rdy=%b, want 0/1", c, ov2, ir2);
            end
         end
         next_cycle();
      end
      v2 = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      or3 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         v3  = (c <= 2) || (c == 4);
         rst = c == 3;
         or3 = c >= 4;
         if (c == 4) applyStimulus(32'h1234_5678, 32'h0, 3'b110, 1'b0, 5'd7);
         else        applyStimulus(32'hDEAD_0000, 32'h0000_BEEF, 3'b100, 1'b0, 5'(c + 1));
         @(negedge clk);
         n_compared++;
         if (c == 3) begin
            if ({ov3, tag3} !== {1'b1, 5'd1}) begin
               n_mismatched++;
               $display("[TB] FAIL rstmid_before: got v=%b t=%0d, want 1/1", ov3, tag3);
            end
         end else if (c == 4) begin
            if ({ov3, res3, tag3, ill3, ir3} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1}) begin
               n_mismatched++;
               $display("[TB] FAIL rstmid_after: got v=%b r=%h t=%h i=%b rdy=%b, want 0/0/0/0/1",
                        ov3, res3, tag3, ill3, ir3);
            end
         end else if (c == 7) begin
            if ({ov3, tag3, res3, ill3} !== {1'b1, 5'd7, 32'h1234_5678, 1'b0}) begin
               n_mismatched++;
               $display("[TB] FAIL rstmid_resume: got v=%b t=%0d r=%h i=%b, want 1/7/12345678/0",
                        ov3, tag3, res3, ill3);
            end
         end else if (c >= 5 && ov3 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_idle c=%0d: got out_valid=%b want 0", c, ov3);
         end
         next_cycle();
      end
      v3 = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_param_sweep();
      exp_t        e;
      logic [64:0] r;
      int          pick;
      logic        draining;
      for (int c = 0; c < 420; c++) begin
         draining = c >= 380;
         sv   = !draining && ($urandom_range(0, 9) < 7);
         sx   = {$urandom, $urandom};
         sy   = {$urandom, $urandom};
         pick = $urandom_range(0, 7);
         sf   = (pick == 0) ? 3'b100 : (pick <= 2) ? 3'b110 : (pick <= 4) ? 3'b111 : 3'($urandom_range(0, 7));
         sinv = 1'($urandom_range(0, 1));
         stag = 1'($urandom_range(0, 1));
         or1  = draining || ($urandom_range(0, 9) < 6);
         or4  = draining || ($urandom_range(0, 9) < 6);
         @(negedge clk);
         if (ov1 && or1) begin
            n_compared++;
            if (q1.size() == 0) begin
               n_mismatched++;
               $display("[TB] FAIL sweep_s1_spurious: got result %h with nothing outstanding", res1);
            end else begin
               e = q1.pop_front();
               if ({res1, tg1, ill1} !== {e.res[7:0], e.tag, e.ill} || cyc - e.cyc < 1) begin
                  n_mismatched++;
                  $display("[TB] FAIL sweep_s1: got r=%h t=%b i=%b lat=%0d, want r=%h t=%b i=%b lat>=1",
                           res1, tg1, ill1, cyc - e.cyc, e.res[7:0], e.tag, e.ill);
               end
            end
         end
         if (ov4 && or4) begin
            n_compared++;
            if (q4.size() == 0) begin
               n_mismatched++;
               $display("[TB] FAIL sweep_s4_spurious: got result %h with nothing outstanding", res4);
            end else begin
               e = q4.pop_front();
               if ({res4, tg4, ill4} !== {e.res, e.tag, e.ill} || cyc - e.cyc < 4) begin
                  n_mismatched++;
                  $display("[TB] FAIL sweep_s4: got r=%h t=%b i=%b lat=%0d, want r=%h t=%b i=%b lat>=4",
                           res4, tg4, ill4, cyc - e.cyc, e.res, e.tag, e.ill);
               end
            end
         end
         r = ref_op(sx, sy, sf, sinv);
         e.res = r[63:0];
         e.ill = r[64];
         e.tag = stag;
         e.cyc = cyc;
         if (sv && ir1) q1.push_back(e);
         if (sv && ir4) q4.push_back(e);
         next_cycle();
      end
      n_compared++;
      if ({q1.size() == 0, q4.size() == 0, ov1, ov4} !== 4'b1100) begin
         n_mismatched++;
         $display("[TB] FAIL sweep_drain: got left1=%0d left4=%0d ov1=%b ov4=%b, want 0 0 0 0",
                  q1.size(), q4.size(), ov1, ov4);
      end
      sv = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_illegal();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_param_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
